// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus types, size/len/burst encodings and the starvation-counter width helper
package mem_bus_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strobe_t;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;
    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;
    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;
    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;
    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;
    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;
    typedef struct packed {
        logic       valid;
        logic       is_write;
        msize_t     size;
        addr_t      addr;
        strobe_t    strobe;
        word_t      data;
        mlen_t      len;
        axi_burst_t burst;
    } cbus_req_t;
    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;
    function automatic int starve_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// mem_bus_arbiter_arb_pick: combinational winner selection between fetch and data requesters
//   ivalid/dvalid  request valids of ibus/dbus
//   starve_cnt     consecutive dbus grants taken while ibus was waiting
//   grant_valid    some requester wants the bus
//   winner         OWN_D unless ibus is alone or starved
module mem_bus_arbiter_arb_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SW = starve_w(STARVE_LIMIT)
) (
    input  logic          ivalid,
    input  logic          dvalid,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_valid,
    output owner_t        winner
);
    assign grant_valid = ivalid | dvalid;
    assign winner = (dvalid && !(ivalid && starve_cnt == SW'(STARVE_LIMIT))) ? OWN_D : OWN_I;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory-side bus between fetch (ibus) and data (dbus), one single-beat transaction at a time
//   clk, reset  clock and asynchronous active-low reset
//   ireq/iresp  fetch port request/response
//   dreq/dresp  data port request/response
//   creq/cresp  memory-side request (registered) and response
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);
    localparam int SW = starve_w(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state;
    owner_t        owner;
    owner_t        winner;
    logic [SW-1:0] starve_cnt;
    logic          grant_valid;
    logic          done;
    cbus_req_t     grant_req;
    mem_bus_arbiter_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .SW(SW)
    ) u_pick (
        .ivalid(ireq.valid),
        .dvalid(dreq.valid),
        .starve_cnt(starve_cnt),
        .grant_valid(grant_valid),
        .winner(winner)
    );
    always_comb begin
        grant_req = '0;
        grant_req.valid = 1'b1;
        grant_req.is_write = (winner == OWN_D) ? |dreq.strobe : 1'b0;
        grant_req.size = (winner == OWN_D) ? dreq.size : MSIZE8;
        grant_req.addr = (winner == OWN_D) ? dreq.addr : ireq.addr;
        grant_req.strobe = (winner == OWN_D) ? dreq.strobe : '0;
        grant_req.data = (winner == OWN_D) ? dreq.data : '0;
        grant_req.len = MLEN1;
        grant_req.burst = AXI_BURST_FIXED;
    end
    // completion is only honoured while a transaction is outstanding
    assign done = (state == BUSY) && cresp.ready && cresp.last;
    always_comb begin
        iresp.addr_ok = done && (owner == OWN_I);
        iresp.data_ok = done && (owner == OWN_I);
        iresp.data = cresp.data;
        dresp.addr_ok = done && (owner == OWN_D);
        dresp.data_ok = done && (owner == OWN_D);
        dresp.data = cresp.data;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= OWN_I;
            starve_cnt <= '0;
            creq <= '0;
        end else if (state == IDLE) begin
            if (grant_valid) begin
                state <= BUSY;
                owner <= winner;
                creq <= grant_req;
                starve_cnt <= (winner == OWN_D && ireq.valid) ? ((starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1) : '0;
            end
        end else if (done) begin
            state <= IDLE;
            creq.valid <= 1'b0;
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory-side bus (`cbus`) between the instruction fetch port (`ibus`) and the data memory port (`dbus`). It grants one outstanding single-beat transaction at a time and latches the winner's request so the memory side sees a stable request. It routes the completion back to the owner only. It sits between the core pipeline (fetch and memory stages) and the memory/cache interface.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive dbus grants while ibus is waiting; the next arbitration then goes to ibus.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `ireq`  in  ibus_req_t  fetch request: valid, addr.
- `iresp`  out  ibus_resp_t  fetch response: addr_ok, data_ok, data.
- `dreq`  in  dbus_req_t  data request: valid, addr, size, strobe, data; write when strobe≠0.
- `dresp`  out  dbus_resp_t  data response: addr_ok, data_ok, data.
- `creq`  out  cbus_req_t  memory request: valid, is_write, size, addr, strobe, data, len (always single beat), burst (always fixed).
- `cresp`  in  cbus_resp_t  memory response: ready, last, data.

## Operation
- States: IDLE, BUSY. A 1-bit `owner` register holds 0 = ibus, 1 = dbus.
- In IDLE, if `ireq.valid` or `dreq.valid` is set, the block picks a winner:
  - Only one valid: that requester wins.
  - Both valid: dbus wins, unless `starve_cnt == STARVE_LIMIT`; then ibus wins.
- On a grant:
  - Latch the winner's fields into the `creq` register and set `creq.valid = 1`.
  - For ibus: is_write = 0, size = 8 bytes, strobe = 0, data = 0.
  - Record `owner` and go to BUSY.
- In BUSY, `creq` stays constant. When `cresp.ready & cresp.last`:
  - The owner's `addr_ok` and `data_ok` pulse high in that cycle, combinationally.
  - The owner's `data` = `cresp.data`.
  - Next edge: `creq.valid = 0` and state goes to IDLE.
- The non-owner's addr_ok and data_ok are always 0. The data field of each response port equals `cresp.data` regardless of owner.
- Starvation counter `starve_cnt`, width clog2(STARVE_LIMIT+1), updated at each grant:
  - dbus grant with `ireq.valid` high: +1, saturating at STARVE_LIMIT.
  - ibus grant, or dbus grant with `ireq.valid` low: cleared to 0.
- Requester protocol: a requester holds valid and its fields stable until it sees data_ok.
  - If a requester drops valid while BUSY, the transaction still completes and data_ok still pulses. No abort exists.
- Reset (asynchronous, any state, including mid-transaction): the transaction is abandoned. Memory side must be reset in the same reset domain.
  - State = IDLE, owner = 0, starve_cnt = 0.
  - creq = all zero, including valid = 0.
  - iresp and dresp addr_ok/data_ok = 0.

## Timing
- Request seen valid in IDLE at cycle 0 → `creq.valid = 1` from cycle 1.
- Memory completes at cycle k ≥ 1 → owner sees data_ok at cycle k (zero-latency response path).
- IDLE again at k+1; a new grant at k+1 produces `creq.valid` at k+2.
  - There is exactly one dead cycle between back-to-back transactions.
- Best-case round trip: 2 cycles (grant, then memory returns ready & last in cycle 1).
- `cresp.ready` without `last` is treated as not done; the single-beat memory side always asserts both together.
- `cresp` is ignored while in IDLE.

## Structure
- ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, cbus_req_t, cbus_resp_t, and the size/burst encodings live in `common`.
- The IDLE/BUSY state enum is local to the module.
- One natural sub-module: `arb_pick`, purely combinational. It takes the two valids and `starve_cnt` and returns grant_valid and the winner.
- Registers: state, owner, starve_cnt, creq.
- Target size: 150–250 lines.

## Test plan
- Single ibus read: addr 0x80000000; memory returns ready & last at cycle 3 with data 0x00000013 → creq.valid cycles 1–3, creq.is_write = 0, iresp.data_ok only at cycle 3 with data 0x13, dresp.data_ok never.
- dbus write: addr 0x80001008, strobe 0xFF, data 0xDEADBEEF, size 8 bytes → creq.is_write = 1 with the fields latched; dresp.data_ok pulses when memory completes.
- Simultaneous requests, both held continuously, STARVE_LIMIT = 4 → grant order is dbus ×4, ibus, dbus ×4, ibus; starve_cnt reads 0, 1, 2, 3, 4, 0, …
- Stability: change dreq.addr while BUSY → creq.addr keeps the latched value until completion.
- Async reset (reset = 0) at mid-BUSY cycle 2 → creq.valid = 0 immediately; state IDLE; no data_ok ever pulses for the abandoned transaction.
- Back-to-back ibus requests with memory always ready → creq.valid pattern 1, 0, 1, 0 and one data_ok every 2 cycles.
